// File: rtl/dpram_tdp_be.sv
// True-dual-port RAM with byte write selects, deterministic same-address write
// resolution (port A wins on shared bytes), optional output register and post-reset clear.
module dpram_tdp_be #(
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 16,
    parameter int MODE           = 0,
    parameter int OREG           = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int SEL_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [SEL_W-1:0]  a_sel,
    input  logic [DATA_W-1:0] a_write,
    input  logic              a_we,
    input  logic              a_ce,
    output logic [DATA_W-1:0] a_read,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [SEL_W-1:0]  b_sel,
    input  logic [DATA_W-1:0] b_write,
    input  logic              b_we,
    input  logic              b_ce,
    output logic [DATA_W-1:0] b_read,
    output logic              busy,
    output logic              collision
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic { S_CLEAR, S_RUN } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   a_rd_q, b_rd_q, a_rd_d, b_rd_d;
    logic                coll_q, coll_d;
    logic                run, a_acc, b_acc, a_wr, b_wr;

    assign run   = (state_q == S_RUN);
    assign a_acc = run & a_ce;
    assign b_acc = run & b_ce;
    assign a_wr  = a_acc & a_we;
    assign b_wr  = b_acc & b_we;
    assign busy  = ~run;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            cnt_q   <= '0;
        end else if (state_q == S_CLEAR) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1)
                state_q <= S_RUN;
        end
    end

    // B is applied first so A's assignment wins on bytes both ports select.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == S_CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else begin
                for (int i = 0; i < SEL_W; i++)
                    if (b_wr && b_sel[i]) mem_q[b_addr][8*i +: 8] <= b_write[8*i +: 8];
                for (int i = 0; i < SEL_W; i++)
                    if (a_wr && a_sel[i]) mem_q[a_addr][8*i +: 8] <= a_write[8*i +: 8];
            end
        end
    end

    // Cross-port reads always see the pre-edge array; write-first only merges own bytes.
    always_comb begin
        a_rd_d = mem_q[a_addr];
        b_rd_d = mem_q[b_addr];
        if (MODE == 1) begin
            for (int i = 0; i < SEL_W; i++) begin
                if (a_wr && a_sel[i]) a_rd_d[8*i +: 8] = a_write[8*i +: 8];
                if (b_wr && b_sel[i]) b_rd_d[8*i +: 8] = b_write[8*i +: 8];
            end
        end
    end

    assign coll_d = a_wr & b_wr & (a_addr == b_addr) & (|(a_sel & b_sel));

    always_ff @(posedge clk) begin
        if (reset) begin
            a_rd_q <= '0;
            b_rd_q <= '0;
            coll_q <= 1'b0;
        end else begin
            if (a_acc) a_rd_q <= a_rd_d;
            if (b_acc) b_rd_q <= b_rd_d;
            coll_q <= coll_d;
        end
    end

    assign collision = coll_q;

    if (OREG != 0) begin : g_oreg
        logic              a_ce_q, b_ce_q;
        logic [DATA_W-1:0] a_o2_q, b_o2_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                a_ce_q <= 1'b0;
                b_ce_q <= 1'b0;
                a_o2_q <= '0;
                b_o2_q <= '0;
            end else begin
                a_ce_q <= a_acc;
                b_ce_q <= b_acc;
                if (a_ce_q) a_o2_q <= a_rd_q;
                if (b_ce_q) b_o2_q <= b_rd_q;
            end
        end
        assign a_read = a_o2_q;
        assign b_read = b_o2_q;
    end else begin : g_noreg
        assign a_read = a_rd_q;
        assign b_read = b_rd_q;
    end
endmodule
